// File: rtl/bioee_sdram_pkg.sv
// rtl/bioee_sdram_pkg.sv - shared types and constants for the SDRAM page arbiter
package bioee_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WACK = 2'd1,
    RACK = 2'd2,
    BUSY = 2'd3
  } arb_state_e;

  localparam int ROW_W      = 15;
  localparam int PAGE_WORDS = 512;

endpackage

// File: rtl/bioee_rr_pick.sv
// rtl/bioee_rr_pick.sv - round-robin picker, search starts after the last grant
module bioee_rr_pick #(
  parameter int NCH = 2,
  localparam int CW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last,
  output logic           valid,
  output logic [CW-1:0]  grant
);

  logic [CW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    grant = last;
    idx   = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = last + CW'(k);
      if (req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/bioee_sdram_page_arbiter.sv
// rtl/bioee_sdram_page_arbiter.sv - multi-channel page scheduler in front of sdramctrl
// Optional: BIOEE_PAGE_ARB_OVERWRITE_EN lets a write to a full region drop the oldest page.
module bioee_sdram_page_arbiter
  import bioee_sdram_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int REGION_LOG2 = 12,
  parameter int TRIG_PAGES  = 1,
  localparam int CW = $clog2(NCH),
  localparam int PW = REGION_LOG2 + 1
) (
  input  logic              sdram_clk,
  input  logic              sdramreset_n,
  input  logic [NCH-1:0]    wr_req,
  input  logic [NCH-1:0]    rd_room,
  input  logic [NCH-1:0]    rd_en,
  input  logic [NCH-1:0]    clear_ovf,
  output logic              cmd_pagewrite,
  output logic              cmd_pageread,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic [ROW_W-1:0]  rowaddr,
  output logic [CW-1:0]     grant_ch,
  output logic              busy,
  output logic [NCH*PW-1:0] fill_pages,
  output logic [NCH-1:0]    fill_level_trigger,
  output logic [NCH-1:0]    overflow
);

  localparam logic [PW-1:0] CAP = PW'(1) << REGION_LOG2;

  arb_state_e state;

  logic [REGION_LOG2-1:0] wptr   [NCH];
  logic [REGION_LOG2-1:0] rptr   [NCH];
  logic [PW-1:0]          cnt    [NCH];
  logic [REGION_LOG2-1:0] wptr_n [NCH];
  logic [REGION_LOG2-1:0] rptr_n [NCH];
  logic [PW-1:0]          cnt_n  [NCH];

  logic [NCH-1:0] full, wr_elig, rd_elig, ovf_n;
  logic [CW-1:0]  last_w, last_r, w_pick, r_pick;
  logic           w_any, r_any;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      full[i] = (cnt[i] == CAP);
`ifdef BIOEE_PAGE_ARB_OVERWRITE_EN
      wr_elig[i] = wr_req[i];
`else
      wr_elig[i] = wr_req[i] && !full[i];
`endif
      rd_elig[i] = rd_en[i] && rd_room[i] && (cnt[i] != '0);
    end
  end

  bioee_rr_pick #(.NCH(NCH)) u_pick_wr (
    .req   (wr_elig),
    .last  (last_w),
    .valid (w_any),
    .grant (w_pick)
  );

  bioee_rr_pick #(.NCH(NCH)) u_pick_rd (
    .req   (rd_elig),
    .last  (last_r),
    .valid (r_any),
    .grant (r_pick)
  );

  // Pointer/count bookkeeping lands on the edge that samples cmd_ack.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wptr_n[i] = wptr[i];
      rptr_n[i] = rptr[i];
      cnt_n[i]  = cnt[i];
      ovf_n[i]  = overflow[i] && !clear_ovf[i];
`ifndef BIOEE_PAGE_ARB_OVERWRITE_EN
      if (wr_req[i] && full[i]) ovf_n[i] = 1'b1;
`endif
      if (cmd_ack && grant_ch == CW'(i)) begin
        if (state == WACK) begin
          wptr_n[i] = wptr[i] + REGION_LOG2'(1);
          if (full[i]) begin
            rptr_n[i] = rptr[i] + REGION_LOG2'(1);
            ovf_n[i]  = 1'b1;
          end else begin
            cnt_n[i] = cnt[i] + PW'(1);
          end
        end else if (state == RACK) begin
          rptr_n[i] = rptr[i] + REGION_LOG2'(1);
          cnt_n[i]  = cnt[i] - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdramreset_n) begin
      for (int i = 0; i < NCH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      overflow           <= '0;
      fill_level_trigger <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wptr[i]               <= wptr_n[i];
        rptr[i]               <= rptr_n[i];
        cnt[i]                <= cnt_n[i];
        fill_level_trigger[i] <= (cnt_n[i] > PW'(TRIG_PAGES));
      end
      overflow <= ovf_n;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdramreset_n) begin
      state         <= IDLE;
      cmd_pagewrite <= 1'b0;
      cmd_pageread  <= 1'b0;
      rowaddr       <= '0;
      grant_ch      <= '0;
      busy          <= 1'b0;
      last_w        <= CW'(NCH - 1);
      last_r        <= CW'(NCH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (w_any) begin
            state         <= WACK;
            cmd_pagewrite <= 1'b1;
            grant_ch      <= w_pick;
            last_w        <= w_pick;
            rowaddr       <= ROW_W'({w_pick, wptr[w_pick]});
            busy          <= 1'b1;
          end else if (r_any) begin
            state        <= RACK;
            cmd_pageread <= 1'b1;
            grant_ch     <= r_pick;
            last_r       <= r_pick;
            rowaddr      <= ROW_W'({r_pick, rptr[r_pick]});
            busy         <= 1'b1;
          end
        end
        WACK: begin
          if (cmd_ack) begin
            state         <= BUSY;
            cmd_pagewrite <= 1'b0;
          end
        end
        RACK: begin
          if (cmd_ack) begin
            state        <= BUSY;
            cmd_pageread <= 1'b0;
          end
        end
        BUSY: begin
          if (cmd_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_fill
    assign fill_pages[g*PW +: PW] = cnt[g];
  end

endmodule
